// File: rtl/nn_operand_loader_if.sv
// Operand-loader bus: host word stream, datapath ready flags and the
// parallel operand bus with its status pulses.
// The master modport is the host/datapath side and the slave modport is the loader.
interface nn_operand_loader_if;
  logic [4:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         out0_ready;
  logic         out1_ready;
  logic [159:0] op_bus;
  logic         in_ready;
  logic         done;
  logic         frame_err;
  logic         timeout;

  modport master (
    output s_data, s_valid, s_last, out0_ready, out1_ready,
    input  s_ready, op_bus, in_ready, done, frame_err, timeout
  );

  modport slave (
    input  s_data, s_valid, s_last, out0_ready, out1_ready,
    output s_ready, op_bus, in_ready, done, frame_err, timeout
  );
endinterface

// File: rtl/nn_operand_loader.sv
// nn_operand_loader: assembles a 28-word serial frame of 5-bit operands into
// the 4-4-2 network's parallel operand bus. It holds in_ready until both
// datapath output flags are seen, or until the compute watchdog expires.
// Optional feature: define NN_LOADER_DBUF_EN for double buffering. The next
// frame then fills the load bank during COMPUTE and is promoted at completion.
module nn_operand_loader #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  nn_operand_loader_if.slave  bus
);

  localparam int         NWORDS  = 28;
  localparam logic [4:0] LAST_K  = 5'd27;
  localparam int         WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {LOAD, COMPUTE} state_t;

  state_t          state_q, state_nxt;
  logic [4:0]      cnt_q, cnt_nxt;
  logic            seen0_q, seen0_nxt;
  logic            seen1_q, seen1_nxt;
  logic [WD_W-1:0] wd_q, wd_nxt;
  logic [139:0]    op_q, op_nxt;
  logic            in_ready_q, in_ready_nxt;
  logic            done_q, done_nxt;
  logic            ferr_q, ferr_nxt;
  logic            tout_q, tout_nxt;
  logic            s_ready_q, s_ready_nxt;
  logic            shadow_q, shadow_nxt;   // load bank holds a complete, unpromoted frame

  logic [4:0]      bank [NWORDS];
  logic [139:0]    held_bank, fresh_bank;
  logic            accept, last_word, frame_ok, frame_bad, complete, wd_expired;

  assign accept     = bus.s_valid && s_ready_q;
  assign last_word  = (cnt_q == LAST_K);
  assign frame_ok   = accept && bus.s_last && last_word;
  assign frame_bad  = accept && (bus.s_last != last_word);
  assign complete   = (seen0_q || bus.out0_ready) && (seen1_q || bus.out1_ready);
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  // Load bank write port: one word per accepted handshake.
  // NOTE: storage arrays are not reset; the word counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (accept) bank[cnt_q] <= bus.s_data;
  end

  // Flatten the bank; fresh_bank also folds in the word being accepted as k=27.
  always_comb begin
    for (int k = 0; k < NWORDS; k++) held_bank[5*k +: 5] = bank[k];
    fresh_bank          = held_bank;
    fresh_bank[139:135] = bus.s_data;
  end

  // Next-state and registered-output logic for the LOAD/COMPUTE sequencer.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    seen0_nxt    = seen0_q;
    seen1_nxt    = seen1_q;
    wd_nxt       = wd_q;
    op_nxt       = op_q;
    in_ready_nxt = in_ready_q;
    shadow_nxt   = shadow_q;
    done_nxt     = 1'b0;
    ferr_nxt     = 1'b0;
    tout_nxt     = 1'b0;

    // Word counter and framing check are shared by both states.
    if (accept) begin
      if (frame_bad) begin
        ferr_nxt = 1'b1;
        cnt_nxt  = '0;
      end else if (last_word) begin
        cnt_nxt  = '0;
      end else begin
        cnt_nxt  = cnt_q + 5'd1;
      end
    end

    unique case (state_q)
      LOAD: begin
        if (frame_ok || shadow_q) begin
          op_nxt       = frame_ok ? fresh_bank : held_bank;
          state_nxt    = COMPUTE;
          in_ready_nxt = 1'b1;
          seen0_nxt    = 1'b0;
          seen1_nxt    = 1'b0;
          wd_nxt       = '0;
          shadow_nxt   = 1'b0;
        end
      end
      COMPUTE: begin
`ifdef NN_LOADER_DBUF_EN
        if (frame_ok) shadow_nxt = 1'b1;
`endif
        if (in_ready_q) begin
          seen0_nxt = seen0_q || bus.out0_ready;
          seen1_nxt = seen1_q || bus.out1_ready;
          wd_nxt    = wd_q + 1'b1;
          if (complete) begin
            done_nxt     = 1'b1;
            in_ready_nxt = 1'b0;
`ifdef NN_LOADER_DBUF_EN
            if (shadow_q || frame_ok) begin
              // Promote the shadow frame; in_ready comes back after one gap cycle.
              op_nxt     = frame_ok ? fresh_bank : held_bank;
              seen0_nxt  = 1'b0;
              seen1_nxt  = 1'b0;
              wd_nxt     = '0;
              shadow_nxt = 1'b0;
            end else begin
              state_nxt  = LOAD;
            end
`else
            state_nxt    = LOAD;
`endif
          end else if (wd_expired) begin
            tout_nxt     = 1'b1;
            in_ready_nxt = 1'b0;
            state_nxt    = LOAD;
          end
        end else begin
          // Gap cycle after a shadow promotion: ready flags are not sampled.
          in_ready_nxt = 1'b1;
        end
      end
      default: state_nxt = LOAD;
    endcase

`ifdef NN_LOADER_DBUF_EN
    s_ready_nxt = !shadow_nxt;
`else
    s_ready_nxt = (state_nxt == LOAD);
`endif
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      seen0_q    <= 1'b0;
      seen1_q    <= 1'b0;
      wd_q       <= '0;
      op_q       <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tout_q     <= 1'b0;
      s_ready_q  <= 1'b1;
      shadow_q   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      seen0_q    <= seen0_nxt;
      seen1_q    <= seen1_nxt;
      wd_q       <= wd_nxt;
      op_q       <= op_nxt;
      in_ready_q <= in_ready_nxt;
      done_q     <= done_nxt;
      ferr_q     <= ferr_nxt;
      tout_q     <= tout_nxt;
      s_ready_q  <= s_ready_nxt;
      shadow_q   <= shadow_nxt;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.op_bus    = {20'b0, op_q};
  assign bus.in_ready  = in_ready_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.timeout   = tout_q;

endmodule

// File: tb/tb_nn_operand_loader.sv
// Self-checking bench for nn_operand_loader. The reference model is the list
// of words last sent as a clean frame, plus the compute-cycle arithmetic for
// when done or timeout must appear.
module tb_nn_operand_loader;

`ifdef NN_LOADER_DBUF_EN
  localparam int TO = 40;
`else
  localparam int TO = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_operand_loader_if bus ();

  nn_operand_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int tout_cnt = 0;
  logic [4:0]   fw [28];
  logic [159:0] exp_bus = '0;

  function automatic logic [159:0] pack_frame();
    logic [159:0] v = '0;
    for (int k = 0; k < 28; k++) v[5*k +: 5] = fw[k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.done)      done_cnt++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.timeout)   tout_cnt++;
  endtask

  task automatic send_word(input logic [4:0] d, input logic last);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.s_ready) check("s_ready_wait", bus.s_ready, 1);
    step();
  endtask

  // bad_k < 0: clean frame; 0..26: s_last early on word bad_k; 27: s_last missing on word 27.
  task automatic send_frame(input int bad_k, input bit gaps);
    int f0 = ferr_cnt;
    for (int k = 0; k < 28; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) step();
      end
      send_word(fw[k], (bad_k < 0) ? (k == 27) : (k == bad_k && bad_k != 27));
      if (bad_k >= 0 && k == bad_k) break;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (bad_k < 0) exp_bus = pack_frame();
    check("frame_err_pulse", bus.frame_err, bad_k >= 0);
    check("frame_err_count", ferr_cnt - f0, (bad_k >= 0) ? 1 : 0);
    check("in_ready_after_frame", bus.in_ready, bad_k < 0);
    check("op_bus_after_frame", bus.op_bus, exp_bus);
  endtask

  // Called in compute cycle 1. d0/d1: cycle in which each flag pulses, 0 = never.
  task automatic run_compute(input int d0, input int d1);
    int  m, end_c, dc0, tc0;
    bit  to;
    dc0   = done_cnt;
    tc0   = tout_cnt;
    m     = (d0 > d1) ? d0 : d1;
    to    = (d0 == 0) || (d1 == 0) || (m > TO);
    end_c = to ? TO : m;
    for (int c = 1; c <= end_c; c++) begin
      bus.out0_ready = (c == d0);
      bus.out1_ready = (c == d1);
      step();
      check("done", bus.done, (c == end_c) && !to);
      check("timeout", bus.timeout, (c == end_c) && to);
      check("in_ready", bus.in_ready, c < end_c);
      check("op_bus_hold", bus.op_bus, exp_bus);
`ifndef NN_LOADER_DBUF_EN
      check("s_ready_compute", bus.s_ready, c == end_c);
`endif
    end
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    step();
    check("done_one_cycle", bus.done, 0);
    check("in_ready_idle", bus.in_ready, 0);
    check("op_bus_after_done", bus.op_bus, exp_bus);
    check("done_pulses", done_cnt - dc0, to ? 0 : 1);
    check("timeout_pulses", tout_cnt - tc0, to ? 1 : 0);
  endtask

  task automatic check_reset_values();
    check("rst_op_bus", bus.op_bus, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_s_ready", bus.s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    step();
    step();
    check_reset_values();
    rst = 1'b0;
    step();

    // Ready flags while loading must not produce a completion.
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    step();
    step();
    check("flags_in_load", bus.done, 0);
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    // Frame 1: x = 4,2,4,1, w04 = 3, ..., w79 = 6; flags on cycles 3 and 7.
    fw[0] = 5'd4; fw[1] = 5'd2; fw[2] = 5'd4; fw[3] = 5'd1; fw[4] = 5'd3;
    for (int k = 5; k < 27; k++) fw[k] = 5'(k % 11);
    fw[27] = 5'd6;
    send_frame(-1, 1'b0);
    check("frame1_word0", bus.op_bus[4:0], 5'b00100);
    check("frame1_word27", bus.op_bus[139:135], 5'b00110);
    check("frame1_reserved", bus.op_bus[159:140], 0);
    run_compute(3, 7);

    // Both flags on the same cycle, then both on the first COMPUTE cycle.
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    send_frame(-1, 1'b0);
    run_compute(4, 4);
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    send_frame(-1, 1'b1);
    run_compute(1, 1);

    // Framing errors: early s_last on word 10, then missing s_last on word 27.
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    send_frame(10, 1'b0);
    send_frame(27, 1'b0);
    for (int k = 0; k < 28; k++) fw[k] = 5'b10000;
    send_frame(-1, 1'b0);
    check("all_10000", bus.op_bus[139:0], {28{5'b10000}});
    run_compute(2, 5);

    // Watchdog: out1_ready is withheld.
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    send_frame(-1, 1'b0);
    run_compute(3, 0);

    // Reset while word 15 of the next frame is offered.
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    for (int k = 0; k < 15; k++) send_word(fw[k], 1'b0);
    bus.s_data = fw[15];
    rst = 1'b1;
    step();
    check_reset_values();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    exp_bus = '0;
    step();
    check("s_ready_after_rst", bus.s_ready, 1);
    for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
    send_frame(-1, 1'b1);
    run_compute(2, 2);

    // Randomized frames with random handshake gaps and flag timing.
    repeat (6) begin
      for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
      send_frame(-1, 1'b1);
      run_compute($urandom_range(1, TO), $urandom_range(1, TO));
    end

`ifdef NN_LOADER_DBUF_EN
    // Double buffering: frame B (all 01111) streams during frame A's compute.
    begin
      logic [159:0] exp_a;
      for (int k = 0; k < 28; k++) fw[k] = 5'($urandom);
      send_frame(-1, 1'b0);
      exp_a = exp_bus;
      for (int k = 0; k < 28; k++) fw[k] = 5'b01111;
      for (int k = 0; k < 28; k++) send_word(fw[k], k == 27);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      check("dbuf_s_ready_full", bus.s_ready, 0);
      check("dbuf_in_ready_a", bus.in_ready, 1);
      check("dbuf_op_bus_a", bus.op_bus, exp_a);
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      step();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      check("dbuf_done", bus.done, 1);
      check("dbuf_in_ready_gap", bus.in_ready, 0);
      check("dbuf_s_ready_back", bus.s_ready, 1);
      exp_bus = pack_frame();
      step();
      check("dbuf_in_ready_b", bus.in_ready, 1);
      check("dbuf_done_cleared", bus.done, 0);
      check("dbuf_op_bus_b", bus.op_bus[139:0], {28{5'b01111}});
      run_compute(2, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_operand_loader.md
# nn_operand_loader

Streaming operand loader that sits in front of the `top` 4-4-2 neural-network datapath. It accepts the 4 signed 5-bit inputs and 28 signed 5-bit weights as a serial stream of 5-bit words over a valid/ready handshake. It assembles them into the parallel operand bus and holds `in_ready` high while the datapath computes. It releases the operands once both `out0_ready` and `out1_ready` have been observed, which closes the loop between a host-side word stream and the network's parallel interface.

## Interface
- `TIMEOUT_CYCLES`, default 64: compute-phase watchdog in cycles; 0 disables the watchdog.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_data` in 5: operand word, two's complement.
- `s_valid` in 1: `s_data`/`s_last` valid.
- `s_last` in 1: marks the final word of a frame.
- `s_ready` out 1: loader accepts a word this cycle.
- `out0_ready` in 1: datapath output-0 valid flag.
- `out1_ready` in 1: datapath output-1 valid flag.
- `op_bus` out 160: word k on bits [5k+4:5k], with this mapping:
  - k=0..3: x0..x3
  - k=4..7: w04, w14, w24, w34
  - k=8..11: w05..w35
  - k=12..15: w06..w36
  - k=16..19: w07..w37
  - k=20..23: w48..w78
  - k=24..27: w49..w79
  - k=28..31: reserved, forced to 0 and not consumed
- `in_ready` out 1: operands valid; drives the datapath `in_ready`.
- `done` out 1: one-cycle pulse when a computation completes.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `timeout` out 1: one-cycle pulse on watchdog expiry.

## Operation
- A frame is exactly 28 words, k=0..27, and `s_last` is high on k=27 only.
- States:
  - LOAD: `s_ready`=1. Each handshake (`s_valid && s_ready`) writes word k to the load bank and increments the 5-bit word counter.
  - COMPUTE: `s_ready`=0 in the base build. `in_ready`=1. Sticky flags `seen0`/`seen1` set on `out0_ready`/`out1_ready`.
- LOAD→COMPUTE: on the handshake of k=27 with `s_last`=1. The load bank is copied to `op_bus`, the counter clears, and `seen0`/`seen1` clear.
- Framing error:
  - Trigger: `s_last`=1 on k<27, or `s_last`=0 on k=27.
  - Response: `frame_err` pulses, the counter returns to 0, the partial frame is discarded, `op_bus` is untouched, and the state stays LOAD.
- COMPUTE→LOAD: when (`seen0` or `out0_ready`) and (`seen1` or `out1_ready`) holds. Flags may arrive in either order, in the same cycle, or on the cycle `in_ready` rises.
- Ready flags are ignored in LOAD.
- `op_bus` holds its value after `done`, until the next frame completes.
- Watchdog:
  - Cycle counter runs in COMPUTE.
  - Reaching `TIMEOUT_CYCLES` without completion pulses `timeout`, goes to LOAD and drops `in_ready`. `done` is not asserted.
- Reset values:
  - `op_bus`=0, `in_ready`=0, `done`=0, `frame_err`=0, `timeout`=0.
  - `s_ready`=1 on the first cycle after reset.
  - State LOAD, counter 0, flags 0.
- Reset mid-frame or mid-compute discards everything. The next word accepted is k=0.

## Timing
- `s_ready` is a registered function of state only; there is no combinational path from `s_valid`.
- `in_ready` and the new `op_bus` both appear the cycle after the k=27 handshake edge.
- Completion:
  - On the edge where the completion condition is true, `in_ready` goes to 0 and `done` goes to 1, both visible the next cycle.
  - `done` lasts exactly 1 cycle.
  - `s_ready` returns to 1 in that same cycle.
- Minimum frame-to-frame period in the base build: 28 load cycles + 1 + compute latency.
- `frame_err` and `timeout` are visible the cycle after the offending edge.

## Configuration
- `NN_LOADER_DBUF_EN` defined: double buffering.
  - `s_ready` stays 1 in COMPUTE and the next frame fills the shadow bank.
  - If the shadow bank completes before the current computation ends, `s_ready` drops to 0 until completion.
  - At completion with a full shadow bank: the shadow is copied to `op_bus` and the state re-enters COMPUTE. `in_ready` is 0 for exactly one cycle alongside `done`, then 1 again.
  - At completion with a partial shadow bank: loading continues in LOAD with no loss of words.
- `NN_LOADER_DBUF_EN` undefined: single bank, and `s_ready`=0 throughout COMPUTE.

## Test plan
- **Frame 1.** Stream x0..x3 = 4,2,4,1 and weights w04=3 … w79=6, with `s_valid` held high.
  - `op_bus`[4:0]=5'b00100 and `op_bus`[139:135]=5'b00110.
  - `in_ready` is 1 one cycle after the 28th handshake.
- **Ready flags on separate cycles.** In COMPUTE, pulse `out0_ready` at cycle 3, then `out1_ready` at cycle 7.
  - `done` pulses once, one cycle after cycle 7.
  - `in_ready` falls in the same cycle as `done`; `op_bus` is unchanged.
- **Ready flags together.** Both flags high on the same cycle, and separately both high in the first COMPUTE cycle: `done` pulses exactly once in each case.
- **Early `s_last`.** Assert `s_last` on word 10.
  - `frame_err` pulses; `in_ready` stays 0.
  - A following clean 28-word frame of all 5'b10000 yields `op_bus`[139:0] with every word 5'b10000.
- **Watchdog.** With `TIMEOUT_CYCLES`=8, withhold `out1_ready`.
  - `timeout` pulses 8 cycles into COMPUTE; `in_ready` is 0 and `done` is never asserted.
  - Apply `rst` at word 15 of the next frame: all outputs return to reset values, and a fresh frame loads correctly.
- **Double buffering** (`NN_LOADER_DBUF_EN` only). Stream frame B, all 5'b01111, during frame A's COMPUTE.
  - After frame A's `done`, `in_ready` is low for 1 cycle.
  - `op_bus` then shows B with all words 5'b01111, and no words are lost.
